// File: rtl/dt_pass_sequencer.sv
// Pixel scheduler for the distance-transform engine: forward raster pass then reverse pass over interior pixels.
// Build option: define DT_SEQ_PERF_EN to add the saturating busy-cycle counter output perf_cycles.
module dt_pass_sequencer #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              pix_dir,
  input  logic              pix_done,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pix_cnt
`ifdef DT_SEQ_PERF_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam int XW = $clog2(IMG_W);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(IMG_W + 1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'((IMG_H - 2) * IMG_W + IMG_W - 2);
  localparam logic [XW-1:0]     X_LO  = XW'(1);
  localparam logic [XW-1:0]     X_HI  = XW'(IMG_W - 2);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FP_ISSUE = 3'd1;
  localparam logic [2:0] S_FP_WAIT  = 3'd2;
  localparam logic [2:0] S_BP_ISSUE = 3'd3;
  localparam logic [2:0] S_BP_WAIT  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              dir_reg, dir_next;
  logic [XW-1:0]     x_cur;
  logic              start_ok;

  assign x_cur    = addr_reg[XW-1:0];
  assign start_ok = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));

  // Stepping past a row edge skips the two border columns of the row being left and entered.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    dir_next   = dir_reg;
    cnt_next   = cnt_reg;
    if (start_ok) begin
      state_next = S_FP_ISSUE;
      addr_next  = FIRST;
      dir_next   = 1'b0;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: ;
        S_FP_ISSUE: if (pix_ready) state_next = S_FP_WAIT;
        S_FP_WAIT: begin
          if (pix_done) begin
            if (addr_reg == LAST) begin
              state_next = S_BP_ISSUE;
              addr_next  = LAST;
              dir_next   = 1'b1;
              cnt_next   = '0;
            end else begin
              state_next = S_FP_ISSUE;
              cnt_next   = cnt_reg + ADDR_W'(1);
              addr_next  = addr_reg + ((x_cur == X_HI) ? ADDR_W'(3) : ADDR_W'(1));
            end
          end
        end
        S_BP_ISSUE: if (pix_ready) state_next = S_BP_WAIT;
        S_BP_WAIT: begin
          if (pix_done) begin
            cnt_next = cnt_reg + ADDR_W'(1);
            if (addr_reg == FIRST) begin
              state_next = S_DONE;
            end else begin
              state_next = S_BP_ISSUE;
              addr_next  = addr_reg - ((x_cur == X_LO) ? ADDR_W'(3) : ADDR_W'(1));
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      dir_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      dir_reg   <= dir_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign pix_valid = (state_reg == S_FP_ISSUE) || (state_reg == S_BP_ISSUE);
  assign busy      = pix_valid || (state_reg == S_FP_WAIT) || (state_reg == S_BP_WAIT);
  assign done      = (state_reg == S_DONE);
  assign pix_addr  = addr_reg;
  assign pix_dir   = dir_reg;
  assign pix_cnt   = cnt_reg;

`ifdef DT_SEQ_PERF_EN
  logic [31:0] perf_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_reg <= '0;
    end else if (start_ok) begin
      perf_reg <= '0;
    end else if (busy && (perf_reg != 32'hFFFF_FFFF)) begin
      perf_reg <= perf_reg + 32'd1;
    end
  end

  assign perf_cycles = perf_reg;
`endif

endmodule

// File: tb/tb_dt_pass_sequencer.sv
// Bench for dt_pass_sequencer: three instances (two 128x128, one 4x4) checked every cycle against a pixel-list model.
module tb_dt_pass_sequencer;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [3];
  logic        start_s [3];
  logic        ready_s [3];
  logic        done_s  [3];
  logic        o_valid [3];
  logic        o_dir   [3];
  logic        o_busy  [3];
  logic        o_done  [3];
  logic [13:0] o_addr  [3];
  logic [13:0] o_cnt   [3];
  logic [3:0]  s_addr, s_cnt;
`ifdef DT_SEQ_PERF_EN
  logic [31:0] o_perf  [3];
`endif

  assign o_addr[2] = {10'd0, s_addr};
  assign o_cnt[2]  = {10'd0, s_cnt};

  dt_pass_sequencer #(.IMG_W(128), .IMG_H(128), .ADDR_W(14)) u_a (
    .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .pix_valid(o_valid[0]), .pix_ready(ready_s[0]),
    .pix_addr(o_addr[0]), .pix_dir(o_dir[0]), .pix_done(done_s[0]), .busy(o_busy[0]), .done(o_done[0]),
    .pix_cnt(o_cnt[0])
`ifdef DT_SEQ_PERF_EN
    , .perf_cycles(o_perf[0])
`endif
  );

  dt_pass_sequencer #(.IMG_W(128), .IMG_H(128), .ADDR_W(14)) u_b (
    .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .pix_valid(o_valid[1]), .pix_ready(ready_s[1]),
    .pix_addr(o_addr[1]), .pix_dir(o_dir[1]), .pix_done(done_s[1]), .busy(o_busy[1]), .done(o_done[1]),
    .pix_cnt(o_cnt[1])
`ifdef DT_SEQ_PERF_EN
    , .perf_cycles(o_perf[1])
`endif
  );

  dt_pass_sequencer #(.IMG_W(4), .IMG_H(4), .ADDR_W(4)) u_s (
    .clk(clk), .reset(rst_s[2]), .start(start_s[2]), .pix_valid(o_valid[2]), .pix_ready(ready_s[2]),
    .pix_addr(s_addr), .pix_dir(o_dir[2]), .pix_done(done_s[2]), .busy(o_busy[2]), .done(o_done[2]),
    .pix_cnt(s_cnt)
`ifdef DT_SEQ_PERF_EN
    , .perf_cycles(o_perf[2])
`endif
  );

  int    img_w [3] = '{128, 128, 4};
  int    img_h [3] = '{128, 128, 4};
  string nm    [3] = '{"A", "B", "S"};

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side engine controls
  bit rmode   [3];
  bit spur    [3];
  bit rdy_req [3];

  // Model: which pass, how many pixels of it completed, whether one is outstanding
  bit m_known  [3];
  bit m_active [3];
  bit m_done   [3];
  bit m_out    [3];
  int m_pass   [3];
  int m_idx    [3];
  int m_perf   [3];

  int tr_a[$];
  int tr_s[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int npix(input int i);
    return (img_w[i] - 2) * (img_h[i] - 2);
  endfunction

  // k-th pixel of a pass: interior pixels listed row-major, reversed for the backward pass
  function automatic int seq_addr(input int i, input int pass, input int k);
    int w, kk;
    w  = img_w[i] - 2;
    kk = (pass != 0) ? npix(i) - 1 - k : k;
    return (1 + kk / w) * img_w[i] + 1 + kk % w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Monitor: model update and engine sampling at the edge, engine drive at +1, compare at negedge
  initial begin
    bit acc   [3];
    bit pend  [3];
    int dly   [3];
    bit d;
    int ea, ed;
    for (int i = 0; i < 3; i++) begin
      ready_s[i] = 1'b0;
      done_s[i]  = 1'b0;
      pend[i]    = 1'b0;
      dly[i]     = 0;
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        acc[i] = o_valid[i] && ready_s[i];
        if (acc[i]) begin
          pend[i] = 1'b1;
          dly[i]  = rmode[i] ? int'($urandom_range(0, 2)) : 0;
          if (i == 0) tr_a.push_back(int'(o_addr[0]) + (o_dir[0] ? 65536 : 0));
          if (i == 2) tr_s.push_back(int'(o_addr[2]) + (o_dir[2] ? 65536 : 0));
        end
        if (rst_s[i] == 1'b0) begin
          m_known[i] = 1'b1; m_active[i] = 1'b0; m_done[i] = 1'b0; m_out[i] = 1'b0;
          m_pass[i] = 0; m_idx[i] = 0; m_perf[i] = 0;
        end else if (m_known[i]) begin
          if (!m_active[i]) begin
            if (start_s[i] == 1'b1) begin
              m_active[i] = 1'b1; m_done[i] = 1'b0; m_out[i] = 1'b0;
              m_pass[i] = 0; m_idx[i] = 0; m_perf[i] = 0;
            end
          end else begin
            m_perf[i]++;
            if (!m_out[i]) begin
              if (ready_s[i] == 1'b1) m_out[i] = 1'b1;
            end else if (done_s[i] == 1'b1) begin
              m_out[i] = 1'b0;
              m_idx[i]++;
              if (m_idx[i] == npix(i)) begin
                if (m_pass[i] == 0) begin
                  m_pass[i] = 1; m_idx[i] = 0;
                end else begin
                  m_active[i] = 1'b0; m_done[i] = 1'b1;
                end
              end
            end
          end
        end
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        d = 1'b0;
        if (pend[i] && dly[i] == 0) begin
          d = 1'b1; pend[i] = 1'b0;
        end else if (pend[i]) begin
          dly[i]--;
        end
        if (rmode[i] && $urandom_range(0, 9) == 0) d = 1'b1;
        done_s[i]  = d | spur[i];
        ready_s[i] = rmode[i] ? ($urandom_range(0, 3) != 0) : rdy_req[i];
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (m_known[i]) begin
          ea = m_active[i] ? seq_addr(i, m_pass[i], m_idx[i]) : (m_done[i] ? seq_addr(i, 1, npix(i) - 1) : 0);
          ed = m_active[i] ? m_pass[i] : (m_done[i] ? 1 : 0);
          chk({nm[i], " pix_valid"}, int'(o_valid[i]), (m_active[i] && !m_out[i]) ? 1 : 0);
          chk({nm[i], " busy"},      int'(o_busy[i]),  int'(m_active[i]));
          chk({nm[i], " done"},      int'(o_done[i]),  int'(m_done[i]));
          chk({nm[i], " pix_addr"},  int'(o_addr[i]),  ea);
          chk({nm[i], " pix_dir"},   int'(o_dir[i]),   ed);
          chk({nm[i], " pix_cnt"},   int'(o_cnt[i]),   m_idx[i]);
`ifdef DT_SEQ_PERF_EN
          chk({nm[i], " perf_cycles"}, int'(o_perf[i]), m_perf[i]);
`endif
        end
      end
    end
  end

  // Stimulus
  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_s[i] = 1'b0; start_s[i] = 1'b0; rmode[i] = 1'b0; spur[i] = 1'b0;
      rdy_req[i] = (i != 0);
    end
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk({nm[i], " reset valid"}, int'(o_valid[i]), 0);
      chk({nm[i], " reset addr"},  int'(o_addr[i]), 0);
      chk({nm[i], " reset busy"},  int'(o_busy[i]), 0);
      rst_s[i] = 1'b1;
    end
    cyc();
    fork
      begin : scen_a
        int nfp;
        start_s[0] = 1'b1; cyc(); start_s[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
          chk("A backpressure valid", int'(o_valid[0]), 1);
          chk("A backpressure addr",  int'(o_addr[0]), 129);
          spur[0] = (k == 1);
          if (k == 4) rdy_req[0] = 1'b1;
          cyc();
        end
        cyc();
        chk("A accepted once", int'(o_valid[0]), 0);
        $display("A: first request accepted after backpressure");
        for (int n = 0; n < 5000 && int'(o_cnt[0]) != 1000; n++) cyc();
        chk("A reached cnt 1000", int'(o_cnt[0]), 1000);
        start_s[0] = 1'b1; cyc(); start_s[0] = 1'b0;
        for (int n = 0; n < 70000 && o_done[0] != 1'b1; n++) cyc();
        chk("A run done", int'(o_done[0]), 1);
        chk("A final cnt", int'(o_cnt[0]), 15876);
        chk("A final busy", int'(o_busy[0]), 0);
        chk("A trace size", tr_a.size(), 31752);
        if (tr_a.size() == 31752) begin
          chk("A trace[0]", tr_a[0], 129);
          chk("A trace[1]", tr_a[1], 130);
          chk("A trace[125]", tr_a[125], 254);
          chk("A trace[126]", tr_a[126], 257);
          chk("A last FP", tr_a[15875], 16254);
          chk("A first BP", tr_a[15876], 65536 + 16254);
          chk("A BP 385", tr_a[31499], 65536 + 385);
          chk("A BP 382", tr_a[31500], 65536 + 382);
          chk("A last BP", tr_a[31751], 65536 + 129);
          nfp = 0;
          foreach (tr_a[j]) if (tr_a[j] < 65536) nfp++;
          chk("A FP request count", nfp, 15876);
        end
`ifdef DT_SEQ_PERF_EN
        // Clean run is 63504 busy cycles; five stalled cycles on the first request add 5
        chk("A perf_cycles", int'(o_perf[0]), 63509);
`endif
        $display("A: full run complete, %0d requests", tr_a.size());
        start_s[0] = 1'b1; cyc(); start_s[0] = 1'b0;
        chk("A restart done", int'(o_done[0]), 0);
        chk("A restart busy", int'(o_busy[0]), 1);
        chk("A restart addr", int'(o_addr[0]), 129);
        chk("A restart dir",  int'(o_dir[0]), 0);
        rmode[0] = 1'b1;
        repeat (2000) cyc();
        rmode[0] = 1'b0;
        $display("A: randomized restart segment complete");
      end
      begin : scen_b
        start_s[1] = 1'b1; cyc(); start_s[1] = 1'b0;
        for (int n = 0; n < 60000 &&
             !(o_busy[1] && !o_valid[1] && o_dir[1] && int'(o_addr[1]) == 8000); n++) cyc();
        chk("B reached BP wait 8000", int'(o_addr[1]), 8000);
        rst_s[1] = 1'b0; cyc(); rst_s[1] = 1'b1;
        chk("B abort valid", int'(o_valid[1]), 0);
        chk("B abort busy",  int'(o_busy[1]), 0);
        chk("B abort cnt",   int'(o_cnt[1]), 0);
        chk("B abort addr",  int'(o_addr[1]), 0);
        $display("B: reset during backward wait at 8000");
        start_s[1] = 1'b1; cyc(); start_s[1] = 1'b0;
        chk("B restart addr",  int'(o_addr[1]), 129);
        chk("B restart valid", int'(o_valid[1]), 1);
        rmode[1] = 1'b1;
        for (int c = 0; c < 3000; c++) begin
          start_s[1] = ($urandom_range(0, 49) == 0);
          cyc();
        end
        start_s[1] = 1'b0; rmode[1] = 1'b0;
        $display("B: randomized segment complete");
      end
      begin : scen_s
        int exp_s [8] = '{5, 6, 9, 10, 65536 + 10, 65536 + 9, 65536 + 6, 65536 + 5};
        start_s[2] = 1'b1; cyc(); start_s[2] = 1'b0;
        for (int n = 0; n < 200 && o_done[2] != 1'b1; n++) cyc();
        chk("S run1 done", int'(o_done[2]), 1);
        chk("S run1 cnt", int'(o_cnt[2]), 4);
`ifdef DT_SEQ_PERF_EN
        chk("S perf_cycles", int'(o_perf[2]), 16);
`endif
        chk("S run1 trace size", tr_s.size(), 8);
        if (tr_s.size() == 8) for (int k = 0; k < 8; k++) chk("S run1 trace", tr_s[k], exp_s[k]);
        $display("S: first run complete");
        spur[2] = 1'b1; cyc();
        start_s[2] = 1'b1; spur[2] = 1'b0; cyc(); start_s[2] = 1'b0;
        chk("S start beats done busy", int'(o_busy[2]), 1);
        chk("S restart addr", int'(o_addr[2]), 5);
        for (int n = 0; n < 200 && o_done[2] != 1'b1; n++) cyc();
        chk("S run2 done", int'(o_done[2]), 1);
        chk("S run2 trace size", tr_s.size(), 16);
        if (tr_s.size() == 16) for (int k = 0; k < 8; k++) chk("S run2 trace", tr_s[8 + k], tr_s[k]);
        $display("S: second run complete");
        rmode[2] = 1'b1;
        for (int c = 0; c < 20000; c++) begin
          start_s[2] = ($urandom_range(0, 15) == 0);
          rst_s[2]   = ($urandom_range(0, 299) != 0);
          cyc();
        end
        start_s[2] = 1'b0; rst_s[2] = 1'b1; rmode[2] = 1'b0;
        $display("S: randomized segment complete");
      end
    join
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dt_pass_sequencer.md
Name: dt_pass_sequencer

Overview:
Scheduler for the distance-transform pixel engine. After `start`, it walks the interior pixels of the IMG_W x IMG_H result image. The forward pass (FP) scans in raster order and the backward pass (BP) in reverse raster order. For each pixel it issues an address to the engine over a valid/ready handshake, then waits for the engine's completion strobe before issuing the next. It sits between top-level control and the neighbour-read/min/write engine and keeps exactly one pixel outstanding.

Parameters:
- IMG_W, 128, image width in pixels; must be a power of two and at least 4.
- IMG_H, 128, image height in pixels; at least 3.
- ADDR_W, 14, pixel address width; equals log2(IMG_W*IMG_H).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-low reset.
- start, input, 1, one-cycle request to begin FP then BP; ignored unless in IDLE or DONE.
- pix_valid, output, 1, a pixel request is presented.
- pix_ready, input, 1, engine accepts the request (valid && ready).
- pix_addr, output, ADDR_W, linear pixel address y*IMG_W+x.
- pix_dir, output, 1, 0 = FP (N/NW/NE/W neighbours), 1 = BP (S/SW/SE/E neighbours).
- pix_done, input, 1, engine finished the outstanding pixel (write committed).
- busy, output, 1, high from the FP start through the last BP completion.
- done, output, 1, high while in DONE.
- pix_cnt, output, ADDR_W, number of pixels completed in the current pass.

Behaviour:
- Reset values (next edge with reset=0): state=IDLE, pix_valid=0, pix_addr=0, pix_dir=0, busy=0, done=0, pix_cnt=0. Reset mid-pass aborts immediately; pix_valid drops at that edge and no further requests are issued.
- Interior region: x in [1, IMG_W-2], y in [1, IMG_H-2]. Border pixels are never issued.
- FIRST = IMG_W+1. LAST = (IMG_H-2)*IMG_W + IMG_W-2. With defaults these are 129 and 16254.
- States and transitions:
  - IDLE: on start, go to FP_ISSUE with pix_addr=FIRST, pix_dir=0, pix_cnt=0.
  - FP_ISSUE: pix_valid=1. Address and dir stay stable until pix_ready=1. On handshake, go to FP_WAIT and drop pix_valid at the same edge.
  - FP_WAIT: on pix_done, pix_cnt increments. If pix_addr==LAST, go to BP_ISSUE with pix_addr=LAST, pix_dir=1, pix_cnt=0. Otherwise step the address: +3 if x==IMG_W-2, else +1; then go to FP_ISSUE.
  - BP_ISSUE / BP_WAIT: same handshake as FP. Step the address: -3 if x==1, else -1. When pix_done arrives with pix_addr==FIRST, go to DONE.
  - DONE: done=1 and busy=0. Holds until start, which restarts as from IDLE.
- x is pix_addr[log2(IMG_W)-1:0]. Steps are modulo 2^ADDR_W but never wrap within the legal range.
- Minimum cost is 2 cycles per pixel (ISSUE with ready=1, then WAIT with done=1). Next request is valid the cycle after pix_done.
- Ignored events:
  - pix_done outside a WAIT state.
  - start while busy=1.
  - pix_ready while pix_valid=0.
- Boundary and corner cases:
  - pix_done in the same cycle as a new start in DONE: start wins.
  - Per-pass pix_cnt final value = (IMG_W-2)*(IMG_H-2), which is 15876 with defaults. It holds that value in DONE.
  - busy = state in {FP_ISSUE, FP_WAIT, BP_ISSUE, BP_WAIT}.

Optional Feature:
- Macro DT_SEQ_PERF_EN.
- Defined: adds output perf_cycles (32 bits). It clears on an accepted start, increments every cycle busy=1, saturates at all-ones, and holds in DONE.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then one start pulse; engine holds ready=1 and asserts done the cycle after each acceptance.
  - FP addresses are 129, 130, ..., 254, 257, ...; 15876 FP requests with pix_dir=0.
  - Then BP starts at 16254, steps 385 -> 382, and ends at 129; 15876 BP requests with pix_dir=1.
  - done=1 thereafter; with DT_SEQ_PERF_EN, perf_cycles=63504.
- Backpressure: hold ready=0 for 5 cycles on the first request.
  - pix_valid stays 1 and pix_addr stays 129 for all 5 cycles.
  - Exactly one acceptance occurs when ready rises.
- Spurious strobes: pulse pix_done during FP_ISSUE, and pulse start mid-FP.
  - Both are ignored; the address sequence and pix_cnt are unchanged.
- Reset asserted during the BP wait at address 8000.
  - Next edge: IDLE, pix_valid=0, busy=0, pix_cnt=0.
  - A subsequent start begins again at 129.
- Restart from DONE: start pulse.
  - done drops, busy=1, pix_addr=129, pix_dir=0.
  - A second full run gives an identical address trace.
- Small configuration IMG_W=4, IMG_H=4.
  - FP addresses 5, 6, 9, 10; BP addresses 10, 9, 6, 5; then done=1.
